// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative absolute-value divider.
package div_pkg;

  // One-hot controller states.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_CALC = 4'b0010,
    S_FIX  = 4'b0100,
    S_DONE = 4'b1000
  } div_state_t;

  // Widest operand the width-generic helpers below can handle.
  localparam int MAX_WIDTH = 64;

  // Number of CALC cycles needed to resolve every quotient bit.
  function automatic int calc_steps(input int data_width, input int step_bits);
    return data_width / step_bits;
  endfunction

  // Mask with the low 'width' bits set.
  function automatic logic [MAX_WIDTH-1:0] width_mask(input int width);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        m = m | (64'd1 << i);
      end
    end
    return m;
  endfunction

  // Two's-complement negation confined to 'width' bits.
  function automatic logic [MAX_WIDTH-1:0] negate_w(input logic [MAX_WIDTH-1:0] value,
                                                    input int width);
    return (~value + 64'd1) & width_mask(width);
  endfunction

  // Magnitude of a 'width'-bit two's-complement value; MIN maps to 2^(width-1).
  function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] value,
                                                 input int width);
    logic [MAX_WIDTH-1:0] masked;
    masked = value & width_mask(width);
    if (masked[6'(width - 1)]) begin
      return negate_w(masked, width);
    end
    return masked;
  endfunction

endpackage

// File: rtl/div_nnbit_abs_step.sv
// One restoring-division step: trial-subtract the divisor from the already
// shifted partial remainder and keep the difference when it does not borrow.
module div_nnbit_abs_step #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH:0] rem_in,
  input  logic [DATA_WIDTH:0] divisor,
  output logic [DATA_WIDTH:0] rem_out,
  output logic                q_bit
);

  logic [DATA_WIDTH+1:0] diff;

  // Extra top bit of the difference acts as the borrow flag.
  always_comb begin
    diff    = {1'b0, rem_in} - {1'b0, divisor};
    q_bit   = ~diff[DATA_WIDTH+1];
    rem_out = q_bit ? diff[DATA_WIDTH:0] : rem_in;
  end

endmodule

// File: rtl/div_nnbit_snn_abs_itera.sv
// Iterative restoring divider on magnitudes, STEP_BITS quotient bits per
// cycle, with valid/ready on both sides, kill, and fixed results for
// divide-by-zero and signed overflow.
module div_nnbit_snn_abs_itera
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STEP_BITS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_num_x,
  input  logic [DATA_WIDTH-1:0] i_num_y,
  input  logic                  i_kill,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic [DATA_WIDTH-1:0] o_rem
);

  localparam int K     = calc_steps(DATA_WIDTH, STEP_BITS);
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  div_state_t state_reg, state_next;

  logic                  accept;
  logic                  x_msb, y_msb, is_zero, is_ovf, last_step;
  logic [DATA_WIDTH-1:0] x_mag, y_mag;
  logic                  signed_reg, q_sign_reg, r_sign_reg, zero_reg, ovf_reg;
  logic [DATA_WIDTH-1:0] x_raw_reg;
  logic [DATA_WIDTH:0]   div_reg, rem_reg;
  logic [DATA_WIDTH-1:0] quo_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_WIDTH:0]   rem_step;
  logic [DATA_WIDTH-1:0] quo_step;
  logic [DATA_WIDTH-1:0] res_fix, rem_fix;

  assign o_ready   = (state_reg == S_IDLE) && !i_rst;
  assign accept    = i_valid && o_ready;
  assign x_msb     = i_num_x[DATA_WIDTH-1];
  assign y_msb     = i_num_y[DATA_WIDTH-1];
  assign x_mag     = i_signed ? DATA_WIDTH'(abs_w(64'(i_num_x), DATA_WIDTH)) : i_num_x;
  assign y_mag     = i_signed ? DATA_WIDTH'(abs_w(64'(i_num_y), DATA_WIDTH)) : i_num_y;
  assign is_zero   = (i_num_y == '0);
  assign is_ovf    = i_signed && (i_num_x == MIN_VAL) && (i_num_y == ALL_ONES);
  assign last_step = (cnt_reg == CNT_W'(K - 1));

  // Step chain: quo_reg starts as |x| and shifts left, feeding dividend bits
  // into the remainder from the top while quotient bits enter at the bottom.
  genvar gi;
  generate
    for (gi = 0; gi < STEP_BITS; gi++) begin : g_step
      logic [DATA_WIDTH:0]   rem_in_s, trial_s, rem_out_s;
      logic [DATA_WIDTH-1:0] quo_in_s, quo_out_s;
      logic                  q_bit_s;

      if (gi == 0) begin : g_first
        assign rem_in_s = rem_reg;
        assign quo_in_s = quo_reg;
      end else begin : g_next
        assign rem_in_s = g_step[gi-1].rem_out_s;
        assign quo_in_s = g_step[gi-1].quo_out_s;
      end

      assign trial_s = (rem_in_s << 1) | (DATA_WIDTH+1)'(quo_in_s[DATA_WIDTH-1]);

      div_nnbit_abs_step #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_step (
        .rem_in (trial_s),
        .divisor(div_reg),
        .rem_out(rem_out_s),
        .q_bit  (q_bit_s)
      );

      assign quo_out_s = {quo_in_s[DATA_WIDTH-2:0], q_bit_s};
    end
  endgenerate

  assign rem_step = g_step[STEP_BITS-1].rem_out_s;
  assign quo_step = g_step[STEP_BITS-1].quo_out_s;

  // Final result selection: special cases first, then sign correction.
  always_comb begin
    res_fix = quo_reg;
    rem_fix = rem_reg[DATA_WIDTH-1:0];
    if (zero_reg) begin
      res_fix = ALL_ONES;
      rem_fix = x_raw_reg;
    end else if (ovf_reg) begin
      res_fix = MIN_VAL;
      rem_fix = '0;
    end else begin
      if (signed_reg && q_sign_reg) begin
        res_fix = DATA_WIDTH'(negate_w(64'(quo_reg), DATA_WIDTH));
      end
      if (signed_reg && r_sign_reg) begin
        rem_fix = DATA_WIDTH'(negate_w(64'(rem_reg[DATA_WIDTH-1:0]), DATA_WIDTH));
      end
    end
  end

  // Next-state logic; kill only matters while a result is still in flight.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = (is_zero || is_ovf) ? S_FIX : S_CALC;
      S_CALC: begin
        if (i_kill) state_next = S_IDLE;
        else if (last_step) state_next = S_FIX;
      end
      S_FIX:  state_next = i_kill ? S_IDLE : S_DONE;
      S_DONE: if (i_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Operand capture, iteration, result formation and output hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      signed_reg <= 1'b0;
      q_sign_reg <= 1'b0;
      r_sign_reg <= 1'b0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      x_raw_reg  <= '0;
      div_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      cnt_reg    <= '0;
      o_valid    <= 1'b0;
      o_res      <= '0;
      o_rem      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            signed_reg <= i_signed;
            q_sign_reg <= i_signed & (x_msb ^ y_msb);
            r_sign_reg <= i_signed & x_msb;
            zero_reg   <= is_zero;
            ovf_reg    <= is_ovf;
            x_raw_reg  <= i_num_x;
            div_reg    <= {1'b0, y_mag};
            rem_reg    <= '0;
            quo_reg    <= x_mag;
            cnt_reg    <= '0;
          end
        end
        S_CALC: begin
          if (!i_kill) begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!i_kill) begin
            o_valid <= 1'b1;
            o_res   <= res_fix;
            o_rem   <= rem_fix;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_res   <= '0;
            o_rem   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
